qif_neuron_scheduler: RTL
=========================

// Module: qif_neuron_scheduler
// PURPOSE
//  Time-multiplexes one 8-bit QIF membrane-update datapath across N_NEURONS neurons.
//  Holds per-neuron V_mem and I_syn state. On each timestep tick, sequences one update per neuron
//  per cycle and queues spike events in a FIFO with a valid/ready output.
//  Sits between the synaptic-input loader (host/router) and the spike-event consumer.
// PARAMETERS
//  N_NEURONS   4      neurons served; index width AW = clog2(N_NEURONS), min 1
//  V_RESET     -20    signed 8-bit reset/post-spike potential
//  V_TH        50     signed 8-bit threshold; spike when stored V >= V_TH
//  FIFO_DEPTH  4      spike-event FIFO entries (power of 2)
// PORTS
//  clk          in   1    clock, all logic on posedge
//  rst_n        in   1    synchronous reset, ACTIVE-HIGH (name retained from the neuron block)
//  tick         in   1    timestep strobe, 1-cycle pulse
//  syn_wr_en    in   1    write I_syn for neuron syn_wr_addr
//  syn_wr_addr  in   AW   neuron index
//  syn_wr_data  in   8    signed synaptic current
//  rd_addr      in   AW   V_mem readback index
//  rd_vmem      out  8    registered V_mem[rd_addr], 1-cycle latency
//  spike_valid  out  1    FIFO head valid
//  spike_id     out  AW   neuron index of head event
//  spike_ready  in   1    consumer accepts head when valid & ready
//  busy         out  1    high while FSM is not IDLE
//  step_done    out  1    1-cycle pulse after the last neuron of a timestep commits
//  tick_overrun out  1    sticky; set when a tick arrives while a tick is already pending
// BEHAVIOUR
//  Reset (rst_n=1 at posedge): all V_mem=V_RESET; all I_syn=0; FIFO empty; FSM=IDLE; idx=0;
//   pending=0; rd_vmem=V_RESET; spike_valid=0; busy=0; step_done=0; tick_overrun=0.
//   Reset mid-timestep aborts the step; no partial state is preserved.
//  FSM states: IDLE, UPDATE, DONE.
//   IDLE: tick or pending -> UPDATE with idx=0; pending is cleared.
//   UPDATE: processes neuron idx this cycle. idx==N_NEURONS-1 and commit -> DONE; else idx++.
//   DONE: step_done=1 for one cycle -> IDLE.
//   Unstalled latency: tick at cycle t, neuron k commits at edge t+1+k,
//    step_done is high in cycle t+1+N_NEURONS.
//  Tick while FSM != IDLE: pending=1. Tick while pending already set: tick_overrun=1 and the tick is dropped.
//  Update for neuron k (V=V_mem[k], I=I_syn[k], 16-bit signed intermediates):
//   if V >= V_TH: V' = V_RESET and push spike k to the FIFO.
//   else: V' = sat8(V + (V/8)*(V/8) + I/4). Division is signed and truncates toward zero.
//    sat8 clamps the result to [-128,127].
//  Stall: if a spike must be pushed and the FIFO is full, no commit occurs and idx holds.
//   A pop in the same cycle frees space, so the push proceeds that cycle.
//  Syn write: takes effect at the edge. If it targets the neuron updating in that cycle, the update
//   uses the old I_syn. I_syn persists across timesteps until rewritten.
//  FIFO: first-word-fall-through; spike_id = head. A pop occurs on valid & ready.
//   Simultaneous push and pop while full or empty is legal; count is unchanged.
//   Spike order equals update order.
//  rd_vmem reflects committed state; a read of the neuron committing this cycle returns the old value.
//  Non-power-of-2 N_NEURONS: addresses >= N_NEURONS are ignored for writes and read back 0.
// TESTING
//  1 reset, no tick, 10 cycles -> rd_vmem of every neuron reads -20; spike_valid=0; busy=0.
//  2 I_syn[0]=100, ready=1, ticks 1..4 -> V0 = 9, 35, 76, then -20 with spike_id=0 on tick 4.
//  3 I_syn=0 on all neurons, 1 tick -> every V = -16; no spikes; step_done in cycle t+5.
//  4 All I_syn=127, ready=0, run until all 4 neurons spike -> FIFO holds 0,1,2,3.
//    Next timestep: V already at V_RESET, no spikes, no stall. Raise ready -> 4 pops, in order.
//  5 FIFO_DEPTH=2, 4 simultaneous spikers, ready=0 -> FSM stalls at idx=2, busy stays 1.
//    ready=1 for 1 cycle -> idx advances; no event lost or duplicated.
//  6 Tick, plus 2 more ticks during UPDATE -> one extra step runs; tick_overrun=1 until reset.

Source files
------------

// File: rtl/qif_neuron_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : qif_neuron_scheduler
//  Description : Shares one 8-bit quadratic integrate-and-fire update datapath
//                across N_NEURONS neurons. A timestep tick walks every neuron
//                once, one per cycle, and queues spike events in a small
//                first-word-fall-through FIFO with a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module qif_neuron_scheduler #(
   parameter int               N_NEURONS  = 4,
   parameter logic signed [7:0] V_RESET   = -8'sd20,
   parameter logic signed [7:0] V_TH      = 8'sd50,
   parameter int               FIFO_DEPTH = 4,
   localparam int              AW         = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick,
   input  logic          syn_wr_en,
   input  logic [AW-1:0] syn_wr_addr,
   input  logic [7:0]    syn_wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_vmem,
   output logic          spike_valid,
   output logic [AW-1:0] spike_id,
   input  logic          spike_ready,
   output logic          busy,
   output logic          step_done,
   output logic          tick_overrun
);

   localparam int            FAW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int            CW     = FAW + 1;
   localparam logic [AW-1:0]  IDX_LAST = AW'(N_NEURONS - 1);
   localparam logic [FAW-1:0] PTR_LAST = FAW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         idx_q, idx_d;
   logic                  pending_q, pending_d;
   logic                  overrun_q, overrun_d;
   logic signed [7:0]     vmem_q [N_NEURONS];
   logic signed [7:0]     vmem_d [N_NEURONS];
   logic signed [7:0]     isyn_q [N_NEURONS];
   logic signed [7:0]     isyn_d [N_NEURONS];
   logic [7:0]            rd_vmem_q, rd_vmem_d;
   logic [AW-1:0]         fifo_q [FIFO_DEPTH];
   logic [AW-1:0]         fifo_d [FIFO_DEPTH];
   logic [FAW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;

   logic signed [7:0]     v_cur, i_cur, v_upd;
   logic signed [15:0]    v16, i16, vq, iq, sum;
   logic                  spike, fifo_full, fifo_empty, pop, push, commit, in_update;

   // Membrane update for the neuron selected by idx: V + (V/8)^2 + I/4, saturated
   always_comb begin
      v_cur = vmem_q[idx_q];
      i_cur = isyn_q[idx_q];
      v16   = 16'(v_cur);
      i16   = 16'(i_cur);
      vq    = v16 / 16'sd8;
      iq    = i16 / 16'sd4;
      sum   = v16 + vq * vq + iq;
      if (sum > 16'sd127)
         v_upd = 8'sd127;
      else if (sum < -16'sd128)
         v_upd = -8'sd128;
      else
         v_upd = sum[7:0];
      spike = (v_cur >= V_TH);
   end

   // Handshake: a spiking neuron commits only if the FIFO has room this cycle
   always_comb begin
      in_update  = (state_q == S_UPDATE);
      fifo_full  = (count_q == CNT_FULL);
      fifo_empty = (count_q == '0);
      pop        = !fifo_empty && spike_ready;
      commit     = in_update && (!spike || !fifo_full || pop);
      push       = commit && spike;
   end

   // Scheduler FSM next-state, timestep pending flag and sticky overrun
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      overrun_d = overrun_q || (tick && pending_q);
      case (state_q)
         S_IDLE: begin
            if (tick || pending_q) begin
               state_d   = S_UPDATE;
               idx_d     = '0;
               pending_d = 1'b0;
            end
         end
         S_UPDATE: begin
            if (tick && !pending_q)
               pending_d = 1'b1;
            if (commit) begin
               if (idx_q == IDX_LAST)
                  state_d = S_DONE;
               else
                  idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (tick && !pending_q)
               pending_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Neuron state arrays, readback register and spike FIFO next values
   always_comb begin
      vmem_d = vmem_q;
      isyn_d = isyn_q;
      fifo_d = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (commit)
         vmem_d[idx_q] = spike ? V_RESET : v_upd;
      if (syn_wr_en && (32'(syn_wr_addr) < N_NEURONS))
         isyn_d[syn_wr_addr] = syn_wr_data;
      if (32'(rd_addr) < N_NEURONS)
         rd_vmem_d = vmem_q[rd_addr];
      else
         rd_vmem_d = 8'd0;
      if (push) begin
         fifo_d[wr_ptr_q] = idx_q;
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop)
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset aborts any step in progress
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         rd_vmem_q <= V_RESET;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         for (int n = 0; n < N_NEURONS; n++) begin
            vmem_q[n] <= V_RESET;
            isyn_q[n] <= 8'sd0;
         end
         for (int f = 0; f < FIFO_DEPTH; f++)
            fifo_q[f] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         rd_vmem_q <= rd_vmem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         vmem_q    <= vmem_d;
         isyn_q    <= isyn_d;
         fifo_q    <= fifo_d;
      end
   end

   assign rd_vmem      = rd_vmem_q;
   assign spike_valid  = !fifo_empty;
   assign spike_id     = fifo_q[rd_ptr_q];
   assign busy         = (state_q != S_IDLE);
   assign step_done    = (state_q == S_DONE);
   assign tick_overrun = overrun_q;

endmodule
`default_nettype wire
